// File: rtl/uart_tx_arb_if.sv
// Requester / transmitter handshake bundle around the UART transmit arbiter.
// The arbiter takes the slave view; the requesters and uart_tx side take master.
interface uart_tx_arb_if;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  done;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_end;
  logic [1:0]  owner;
  logic        active;
  logic        timeout;

  modport master (
    output req, req_data, tx_busy, tx_end,
    input  ack, done, tx_start, tx_data, owner, active, timeout
  );

  modport slave (
    input  req, req_data, tx_busy, tx_end,
    output ack, done, tx_start, tx_data, owner, active, timeout
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter handing one byte at a time from four requesters to a
// single UART transmitter, with a watchdog that aborts a transfer whose
// tx_end never arrives. Every output comes straight from a flop.
module uart_tx_arb #(
  parameter int TO_W = 16
) (
  input logic        clk,
  input logic        reset,
  uart_tx_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [TO_W-1:0] TERM = {TO_W{1'b1}};

  state_t          state_q, state_d;
  logic [1:0]      rr_q, rr_d;
  logic [1:0]      owner_q, owner_d;
  logic [7:0]      data_q, data_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            start_q, start_d;
  logic [3:0]      ack_q, ack_d;
  logic [3:0]      done_q, done_d;
  logic            active_q, active_d;
  logic            to_q, to_d;
  logic [1:0]      sel;

  // First set request bit found when searching p, p+1, ... modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  // Watchdog increment that parks at the terminal count instead of wrapping.
  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] c);
    return (c == TERM) ? c : c + TO_W'(1);
  endfunction

  assign sel = rr_pick(bus.req, rr_q);

  // Next-state and next-output decode; the counter reads 0 during START and
  // equals the WAIT cycle number (1, 2, ...) during WAIT.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    ack_d    = 4'b0000;
    done_d   = 4'b0000;
    active_d = 1'b0;
    to_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.tx_busy && (bus.req != 4'b0000)) begin
          owner_d  = sel;
          data_d   = bus.req_data[{sel, 3'b000} +: 8];
          cnt_d    = '0;
          start_d  = 1'b1;
          ack_d    = 4'b0001 << sel;
          active_d = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        cnt_d    = sat_inc(cnt_q);
        active_d = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (bus.tx_end) begin
          // tx_end takes priority over a simultaneous terminal count
          done_d  = 4'b0001 << owner_q;
          rr_d    = owner_q + 2'd1;
          state_d = IDLE;
        end else if (cnt_q == TERM) begin
          to_d    = 1'b1;
          rr_d    = owner_q + 2'd1;
          state_d = IDLE;
        end else begin
          cnt_d    = sat_inc(cnt_q);
          active_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_q     <= 2'd0;
      owner_q  <= 2'd0;
      data_q   <= 8'h00;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      ack_q    <= 4'b0000;
      done_q   <= 4'b0000;
      active_q <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      active_q <= active_d;
      to_q     <= to_d;
    end
  end

  assign bus.tx_start = start_q;
  assign bus.tx_data  = data_q;
  assign bus.ack      = ack_q;
  assign bus.done     = done_q;
  assign bus.owner    = owner_q;
  assign bus.active   = active_q;
  assign bus.timeout  = to_q;

endmodule
